// File: rtl/fire9_expand1_ofm_writer_if.sv
// ---------------------------------------------------------------------------
// fire9_expand1_ofm_writer_if
// Multi-lane RAM write bus driven by the fire9 expand1x1 OFM writer.
//   wr_en_o    : write strobe shared by all lanes
//   wr_addr_o  : per-lane write address shared by all lanes
//   wr_data_o  : one WIDTH-bit word per lane
// Modports: master (writer side, drives the bus), slave (RAM side).
// ---------------------------------------------------------------------------
interface fire9_expand1_ofm_writer_if #(
  parameter int WIDTH  = 16,
  parameter int LANES  = 4,
  parameter int ADDR_W = 13
);
  logic                         wr_en_o;
  logic [ADDR_W-1:0]            wr_addr_o;
  logic [LANES-1:0][WIDTH-1:0]  wr_data_o;

  modport master (
    output wr_en_o,
    output wr_addr_o,
    output wr_data_o
  );

  modport slave (
    input wr_en_o,
    input wr_addr_o,
    input wr_data_o
  );
endinterface

// File: rtl/fire9_expand1_ofm_writer.sv
// ---------------------------------------------------------------------------
// fire9_expand1_ofm_writer
// Sink for the fire9 expand1x1 layer. A DSP_NO-wide OFM pixel vector is
// captured into a shadow bank on each sample strobe and drained over LANES
// RAM write lanes, one channel per lane per cycle, into a channel-major
// buffer (addr = channel*WOUT*WOUT + pixel). After the last pixel vector of
// the frame has been stored, ram_feedback pulses for one cycle.
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   sample_i     1-cycle strobe, ofm_i valid
//   ofm_i        unpacked OFM vector, channel 0..DSP_NO-1
//   wr           RAM write bus (master modport)
//   busy_o       high while a captured vector is being written out
//   ram_feedback 1-cycle pulse once the whole frame is written
//   overflow_o   sticky, set when a sample strobe had to be dropped
// ---------------------------------------------------------------------------
module fire9_expand1_ofm_writer #(
  parameter int WIDTH  = 16,
  parameter int DSP_NO = 368,
  parameter int WOUT   = 8,
  parameter int LANES  = 4,
  parameter int ADDR_W = $clog2((DSP_NO / LANES) * WOUT * WOUT)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_i,
  input  logic [WIDTH-1:0]           ofm_i [DSP_NO],
  fire9_expand1_ofm_writer_if.master wr,
  output logic                       busy_o,
  output logic                       ram_feedback,
  output logic                       overflow_o
);

  localparam int CPL   = DSP_NO / LANES;
  localparam int NPIX  = WOUT * WOUT;
  localparam int CH_W  = $clog2(CPL);
  localparam int PIX_W = $clog2(NPIX);
  localparam int IDX_W = $clog2(DSP_NO);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state;
  logic [CH_W-1:0]  ch_cnt;
  logic [PIX_W-1:0] pix_cnt;
  logic [WIDTH-1:0] shadow_p0 [DSP_NO];

  logic last_ch;
  logic last_pix;
  logic accept;

  // Channel-major layout: every channel owns a contiguous WOUT*WOUT block.
  function automatic logic [ADDR_W-1:0] addr_of(input logic [CH_W-1:0]  ch,
                                                input logic [PIX_W-1:0] pix);
    return ADDR_W'(ch) * ADDR_W'(NPIX) + ADDR_W'(pix);
  endfunction

  assign last_ch  = (ch_cnt == CH_W'(CPL - 1));
  assign last_pix = (pix_cnt == PIX_W'(NPIX - 1));

  // A strobe is taken when idle, or on the final channel of a non-final
  // pixel so back-to-back vectors drain without a bubble.
  assign accept = sample_i &&
                  ((state == ST_IDLE) ||
                   ((state == ST_DRAIN) && last_ch && !last_pix));

  // Stage p0: capture bank (data only, no reset)
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int c = 0; c < DSP_NO; c++) begin
        shadow_p0[c] <= ofm_i[c];
      end
    end
  end

  // Stage p1: control FSM and registered write bus
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      ch_cnt        <= '0;
      pix_cnt       <= '0;
      wr.wr_en_o    <= 1'b0;
      wr.wr_addr_o  <= '0;
      wr.wr_data_o  <= '0;
      busy_o        <= 1'b0;
      ram_feedback  <= 1'b0;
      overflow_o    <= 1'b0;
    end else begin
      wr.wr_en_o   <= 1'b0;
      busy_o       <= 1'b0;
      ram_feedback <= 1'b0;

      if (sample_i && !accept) begin
        overflow_o <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (sample_i) begin
            ch_cnt <= '0;
            state  <= ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          wr.wr_en_o   <= 1'b1;
          busy_o       <= 1'b1;
          wr.wr_addr_o <= addr_of(ch_cnt, pix_cnt);
          for (int l = 0; l < LANES; l++) begin
            wr.wr_data_o[l] <= shadow_p0[IDX_W'(l * CPL) + IDX_W'(ch_cnt)];
          end

          if (last_ch) begin
            ch_cnt <= '0;
            if (last_pix) begin
              pix_cnt <= '0;
              state   <= ST_DONE;
            end else begin
              pix_cnt <= pix_cnt + PIX_W'(1);
              state   <= sample_i ? ST_DRAIN : ST_IDLE;
            end
          end else begin
            ch_cnt <= ch_cnt + CH_W'(1);
          end
        end

        ST_DONE: begin
          ram_feedback <= 1'b1;
          state        <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
